// File: rtl/divr1r2r3_seq.sv
// Iterative restoring divider r1 = r2 / r3, remainder r4, one shift-subtract step per clock.
// Optional two's-complement operation is enabled by defining DIVR1R2R3_SIGNED_EN.
module divr1r2r3_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r4,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             dz;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             last;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;
  logic             v_res;

`ifdef DIVR1R2R3_SIGNED_EN
  logic sq;
  logic sr;
  logic ovf;

  assign a_mag = r2[WIDTH-1] ? (~r2 + 1'b1) : r2;
  assign b_mag = r3[WIDTH-1] ? (~r3 + 1'b1) : r3;
`else
  assign a_mag = r2;
  assign b_mag = r3;
`endif

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);
  assign last = (cnt == CNT_W'(WIDTH - 1));

  // rem < dvs holds between steps (or rem_sh[WIDTH]=0 when dvs=0), so the
  // WIDTH+1-bit difference never overflows and its MSB is the borrow.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign borrow = diff[WIDTH];
  assign rem_nx = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nx = {quo[WIDTH-2:0], ~borrow};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    q_res = quo_nx;
    r_res = rem_nx;
    v_res = dz;
`ifdef DIVR1R2R3_SIGNED_EN
    if (sq) q_res = ~quo_nx + 1'b1;
    if (sr) r_res = ~rem_nx + 1'b1;
    if (dz) q_res = '1;
    v_res = dz | ovf;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      dz    <= 1'b0;
      r1    <= '0;
      r4    <= '0;
      n     <= 1'b0;
      z     <= 1'b0;
      c     <= 1'b0;
      v     <= 1'b0;
`ifdef DIVR1R2R3_SIGNED_EN
      sq    <= 1'b0;
      sr    <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_CALC;
            cnt   <= '0;
            rem   <= '0;
            quo   <= a_mag;
            dvs   <= b_mag;
            dz    <= (r3 == '0);
`ifdef DIVR1R2R3_SIGNED_EN
            sq    <= r2[WIDTH-1] ^ r3[WIDTH-1];
            sr    <= r2[WIDTH-1];
            ovf   <= (r2 == {1'b1, {(WIDTH-1){1'b0}}}) && (r3 == '1);
`endif
          end
        end
        S_CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            // Results land on the edge entering FIN so they are valid with done.
            state <= S_FIN;
            r1    <= q_res;
            r4    <= r_res;
            n     <= q_res[WIDTH-1];
            z     <= (q_res == '0);
            c     <= (r_res != '0);
            v     <= v_res;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divr1r2r3_seq.sv
// Scoreboard bench for divr1r2r3_seq: driver pushes expected results, monitor checks on done.
// Expectations for the last directed pair follow DIVR1R2R3_SIGNED_EN.
module tb_divr1r2r3_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] r2;
  logic [31:0] r3;
  logic        busy;
  logic        done;
  logic [31:0] r1;
  logic [31:0] r4;
  logic        n;
  logic        z;
  logic        c;
  logic        v;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  divr1r2r3_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .r2    (r2),
    .r3    (r3),
    .busy  (busy),
    .done  (done),
    .r1    (r1),
    .r4    (r4),
    .n     (n),
    .z     (z),
    .c     (c),
    .v     (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", r1, e.q);
        check("remainder", r4, e.r);
        check("flags_nzcv", {28'd0, n, z, c, v}, {28'd0, e.f});
      end
    end
  end

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er,
                     input logic [3:0] ef, input bit glitch);
    exp_t e;
    int   cyc;
    bit   got;
    bit   busy_ok;
    e.q = eq; e.r = er; e.f = ef;
    sb.push_back(e);
    @(negedge clk);
    r2 = a; r3 = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    r2 = $urandom; r3 = $urandom;
    cyc = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) got = 1'b1;
      if (glitch && (cyc == 5 || got)) begin
        start = 1'b1; r2 = 32'd5; r3 = 32'd9;
      end else if (glitch && cyc == 6) begin
        start = 1'b0;
      end
    end
    check("done_seen", {31'd0, got}, 32'd1);
    check("latency", cyc, 32'd33);
    check("busy_window", {31'd0, busy_ok}, 32'd1);
    if (!glitch) begin
      @(negedge clk);
      check("idle_after_done", {30'd0, busy, done}, 32'd0);
    end
  endtask

  initial begin
    int dcount;
    rst_n = 1'b1; start = 1'b0; r2 = '0; r3 = '0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_ctrl", {26'd0, busy, done, n, z, c, v}, 32'd0);
    check("reset_r1", r1, 32'd0);
    check("reset_r4", r4, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(32'd100, 32'd7, 32'd14, 32'd2, 4'b0010, 1'b0);
    run(32'd5, 32'd9, 32'd0, 32'd5, 4'b0110, 1'b0);
    run(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'b1000, 1'b0);
    // Restarts at cycles 5 and 33 must be dropped; the next launch lands on the edge after done.
    run(32'd100, 32'd7, 32'd14, 32'd2, 4'b0010, 1'b1);
    run(32'd1000, 32'd10, 32'd100, 32'd0, 4'b0000, 1'b0);
`ifdef DIVR1R2R3_SIGNED_EN
    run(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b1010, 1'b0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 4'b1001, 1'b0);
`else
    run(32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 4'b0010, 1'b0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 4'b0110, 1'b0);
`endif
    run(32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 4'b1011, 1'b0);

    // Abort an operation with reset in cycle 10.
    @(negedge clk);
    r2 = 32'd100; r3 = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_ctrl", {26'd0, busy, done, n, z, c, v}, 32'd0);
    check("abort_r1", r1, 32'd0);
    check("abort_r4", r4, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    check("no_done_after_abort", dcount, 32'd0);

    run(32'h1234_5678, 32'h0000_0100, 32'h0012_3456, 32'h0000_0078, 4'b0010, 1'b0);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/divr1r2r3_seq.md
Name: divr1r2r3_seq

Overview:
- Iterative 32-bit restoring divider for the processor datapath: r1 = r2 / r3, remainder on r4.
- Produces n/z/c/v flags consistent with the existing r1/r2/r3 arithmetic units.
- Uses one shift-subtract step per clock, under a start/busy/done handshake.
- Sits beside the single-cycle ALU blocks; the control unit stalls on busy.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only on a rising edge with busy=0
- r2  input  WIDTH  dividend; sampled on the accepting edge
- r3  input  WIDTH  divisor; sampled on the accepting edge
- busy  output  1  high from the cycle after acceptance until done drops
- done  output  1  one-cycle pulse; results valid from this cycle
- r1  output  WIDTH  quotient, registered
- r4  output  WIDTH  remainder, registered
- n, z, c, v  output  1 each  flags, registered

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy=0, done=0, r1=0, r4=0, n=z=c=v=0; counter=0.
- Reset asserted mid-operation aborts immediately; no done pulse follows.
- States: IDLE, CALC, FIN.
- IDLE: start=1 at an edge latches r2, r3, clears the partial remainder, counter=0, and moves to CALC. Otherwise stays in IDLE.
- CALC, each cycle:
  - Shift {rem, quo} left one bit, bringing in the next dividend MSB.
  - Trial subtract rem - divisor at WIDTH+1 bits.
  - If no borrow: keep the difference and set the quotient LSB to 1; else restore rem and set the LSB to 0.
  - counter increments; after WIDTH iterations, go to FIN.
- FIN: register r1, r4 and flags; done=1 for exactly this cycle; next state IDLE.
- Latency: accepted at edge 0 -> busy=1 in cycles 1..WIDTH+1 -> done=1 in cycle WIDTH+1 (cycle 33 by default).
- Outputs r1/r4/flags hold their values until the next FIN.
- start while busy=1, including during FIN, is ignored and not queued. Earliest next acceptance is the edge after done.
- Operand changes after acceptance have no effect.
- Flags, computed at FIN:
  - n = r1[WIDTH-1]
  - z = (r1 == 0)
  - c = (r4 != 0), i.e. inexact division
  - v = divide-by-zero, or signed overflow (optional feature only)
- Divide by zero: no special path; the full latency runs. The natural restoring result gives r1 = all ones and r4 = r2; v=1.

Optional Feature:
- Macro: DIVR1R2R3_SIGNED_EN.
- Defined:
  - Operands are two's complement. At acceptance, magnitudes are taken and the signs recorded.
  - At FIN, the quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - Most-negative / -1 gives r1 = most-negative, r4 = 0, v=1.
  - Divide by zero gives r1 = all ones, r4 = r2, v=1.
  - Latency is unchanged.
- Undefined: unsigned only, as above; no sign logic is synthesized.

Test Plan:
- Reset, then r2=100, r3=7, start pulse -> done exactly in cycle 33; r1=14, r4=2; n=0 z=0 c=1 v=0; busy=1 in cycles 1..33.
- r2=5, r3=9 -> r1=0, r4=5; z=1, c=1. Then r2=0xFFFFFFFF, r3=1 -> r1=0xFFFFFFFF, r4=0; n=1, c=0, v=0.
- r2=0x1234, r3=0 -> after 33 cycles r1=0xFFFFFFFF, r4=0x1234; v=1, n=1.
- start re-pulsed with new operands at cycles 5 and 33 -> both ignored; the first result is unchanged. A start on the edge after done is accepted and gives a correct second result.
- rst_n pulsed low at cycle 10 -> all outputs 0 asynchronously, no done. A fresh start afterwards completes normally.
- DIVR1R2R3_SIGNED_EN defined:
  - -7/2 -> r1=-3 (0xFFFFFFFD), r4=-1; n=1, c=1.
  - 0x80000000 / 0xFFFFFFFF -> r1=0x80000000, r4=0; v=1.
